// File: rtl/cardrom_pkg.sv
// Shared definitions for the card-ROM loader: loader state encoding,
// RAM address width and the default depth / timeout constants.
package cardrom_pkg;

  localparam int ROM_ADDR_W             = 11;
  localparam int ROM_DEPTH_DEFAULT      = 2048;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_e;

  // States in which the loader accepts bytes from the image stream.
  function automatic logic is_busy_state(input loader_state_e st);
    return (st == ST_LOAD) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/card_rom_checksum.sv
// Modulo-256 accumulator over the image bytes. sum_is_zero reports whether
// the sum, including the byte presented this cycle when add_en is high,
// is 0x00, so the loader can judge the final checksum byte without waiting
// a cycle.
module card_rom_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] data,
  output logic       sum_is_zero
);

  logic [7:0] sum_r;
  logic [7:0] sum_s;

  // Next value of the running sum.
  always_comb begin
    sum_s = sum_r;
    if (add_en) begin
      sum_s = sum_r + data;
    end else begin
      sum_s = sum_r;
    end
  end

  assign sum_is_zero = (sum_s == 8'h00);

  // Running sum register, cleared at the start of each load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_r <= 8'h00;
    end else if (clear) begin
      sum_r <= 8'h00;
    end else begin
      sum_r <= sum_s;
    end
  end

endmodule

// File: rtl/card_rom_loader.sv
// Card-ROM image loader: streams ROM_DEPTH bytes into the card-ROM RAM,
// supervises inter-byte gaps with a timeout and, after a good load,
// raises a level request for the card-ROM responder to release the ROM.
// Optional feature macro: CARD_ROM_LOADER_CHECKSUM_EN adds a trailing
// checksum byte (CHECK state) that must bring the modulo-256 sum to 0x00.
module card_rom_loader
  import cardrom_pkg::*;
#(
  parameter int ROM_DEPTH      = ROM_DEPTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk_logic,
  input  logic                  system_reset_n,
  input  logic                  start_i,
  input  logic [7:0]            s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [ROM_ADDR_W-1:0] wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic                  wr_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  req_rom_release_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_e         state_r;
  loader_state_e         state_s;
  logic                  xfer_s;
  logic                  load_xfer_s;
  logic                  start_ok_s;
  logic                  last_s;
  logic                  timeout_s;
  logic [ROM_ADDR_W-1:0] byte_cnt_r;
  logic [TO_W-1:0]       idle_cnt_r;

  logic                  s_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  error_r;
  logic                  release_r;
  logic                  wr_en_r;
  logic [ROM_ADDR_W-1:0] wr_addr_r;
  logic [7:0]            wr_data_r;

  assign xfer_s      = s_valid_i & s_ready_r;
  assign load_xfer_s = xfer_s & (state_r == ST_LOAD);
  assign start_ok_s  = start_i & ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                  (state_r == ST_ERROR));
  assign last_s      = (byte_cnt_r == ROM_ADDR_W'(ROM_DEPTH - 1));
  // A transfer always wins over an expiring timeout in the same cycle.
  assign timeout_s   = is_busy_state(state_r) & ~xfer_s &
                       (idle_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef CARD_ROM_LOADER_CHECKSUM_EN
  logic sum_zero_s;

  card_rom_checksum u_checksum (
    .clk         (clk_logic),
    .rst_n       (system_reset_n),
    .clear       (start_ok_s),
    .add_en      (xfer_s),
    .data        (s_data_i),
    .sum_is_zero (sum_zero_s)
  );
`endif

  // Next-state logic for the load sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_s = ST_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          if (last_s) begin
`ifdef CARD_ROM_LOADER_CHECKSUM_EN
            state_s = ST_CHECK;
`else
            state_s = ST_DONE;
`endif
          end else begin
            state_s = ST_LOAD;
          end
        end else if (timeout_s) begin
          state_s = ST_ERROR;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_CHECK: begin
`ifdef CARD_ROM_LOADER_CHECKSUM_EN
        if (xfer_s) begin
          state_s = sum_zero_s ? ST_DONE : ST_ERROR;
        end else if (timeout_s) begin
          state_s = ST_ERROR;
        end else begin
          state_s = ST_CHECK;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered status flags decoded from the next state.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      state_r   <= ST_IDLE;
      s_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      s_ready_r <= is_busy_state(state_s);
      busy_r    <= is_busy_state(state_s);
      done_r    <= (state_s == ST_DONE);
      error_r   <= (state_s == ST_ERROR);
      release_r <= (state_s == ST_DONE);
    end
  end

  // Byte index of the next image byte; holds at the last index.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      byte_cnt_r <= {ROM_ADDR_W{1'b0}};
    end else if (start_ok_s) begin
      byte_cnt_r <= {ROM_ADDR_W{1'b0}};
    end else if (load_xfer_s && !last_s) begin
      byte_cnt_r <= byte_cnt_r + {{(ROM_ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Cycles since the last transfer while loading.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      idle_cnt_r <= {TO_W{1'b0}};
    end else if (start_ok_s || xfer_s) begin
      idle_cnt_r <= {TO_W{1'b0}};
    end else if (is_busy_state(state_r) && !timeout_s) begin
      idle_cnt_r <= idle_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    end
  end

  // RAM write port, one cycle behind each LOAD transfer.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ROM_ADDR_W{1'b0}};
      wr_data_r <= 8'h00;
    end else begin
      wr_en_r <= load_xfer_s;
      if (load_xfer_s) begin
        wr_addr_r <= byte_cnt_r;
        wr_data_r <= s_data_i;
      end
    end
  end

  assign s_ready_o         = s_ready_r;
  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign error_o           = error_r;
  assign req_rom_release_o = release_r;
  assign wr_en_o           = wr_en_r;
  assign wr_addr_o         = wr_addr_r;
  assign wr_data_o         = wr_data_r;

endmodule

// File: tb/tb_card_rom_loader.sv
// Self-checking bench for card_rom_loader (ROM_DEPTH=2048, TIMEOUT_CYCLES=16).
// Image byte i is i[7:0]; expected RAM writes are queued at each handshake
// and popped when wr_en_o is due one cycle later.
module tb_card_rom_loader;
  import cardrom_pkg::*;

  localparam int DEPTH = 2048;
  localparam int TO    = 16;

  logic        clk_logic = 1'b0;
  logic        system_reset_n;
  logic        start_i;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [10:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        wr_en_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic        req_rom_release_o;

  always #5 clk_logic = ~clk_logic;

  card_rom_loader #(.ROM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_logic         (clk_logic),
    .system_reset_n    (system_reset_n),
    .start_i           (start_i),
    .s_data_i          (s_data_i),
    .s_valid_i         (s_valid_i),
    .s_ready_o         (s_ready_o),
    .wr_addr_o         (wr_addr_o),
    .wr_data_o         (wr_data_o),
    .wr_en_o           (wr_en_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .error_o           (error_o),
    .req_rom_release_o (req_rom_release_o)
  );

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       new_load;
    logic       r, b, d, e, rel;
  } vec_t;

  wr_exp_t exp_q[$];
  int      vectors     = 0;
  int      miscompares = 0;
  int      idx         = 0;
  logic    pending     = 1'b0;
  int      wr_count    = 0;
  int      rel_rises   = 0;
  logic    rel_prev    = 1'b0;
  int      start_tok   = 0;
  int      seen_tok    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags(input string name, input logic r, input logic b,
                           input logic d, input logic e, input logic rel);
    chk(name, 32'({s_ready_o, busy_o, done_o, error_o, req_rom_release_o}),
        32'({r, b, d, e, rel}));
  endtask

  // Scoreboard: check the write due from the previous handshake, then
  // queue the write expected from the handshake at the coming edge.
  task automatic mon_sample();
    wr_exp_t e;
    if (pending || wr_en_o) begin
      if (pending && (exp_q.size() > 0)) begin
        e = exp_q.pop_front();
        chk("wr_en", 32'(wr_en_o), 32'd1);
        chk("wr_addr", 32'(wr_addr_o), 32'(e.addr));
        chk("wr_data", 32'(wr_data_o), 32'(e.data));
      end else begin
        chk("spurious_wr_en", 32'(wr_en_o), 32'd0);
      end
    end
    if (wr_en_o) wr_count++;
    if (req_rom_release_o && !rel_prev) rel_rises++;
    rel_prev = req_rom_release_o;
    if (start_tok != seen_tok) begin
      idx      = 0;
      seen_tok = start_tok;
    end
    pending = 1'b0;
    if (s_valid_i && s_ready_o && system_reset_n) begin
      if (idx < DEPTH) begin
        e.addr = idx[10:0];
        e.data = idx[7:0];
        exp_q.push_back(e);
        pending = 1'b1;
      end
      idx++;
    end
  endtask

  task automatic step();
    @(negedge clk_logic);
    mon_sample();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input int gap);
    if (gap > 0) begin
      s_valid_i = 1'b0;
      repeat (gap) step();
    end
    s_valid_i = 1'b1;
    s_data_i  = d;
    chk("ready_when_loading", 32'(s_ready_o), 32'd1);
    step();
  endtask

  task automatic load_bytes(input int from, input int to, input int max_gap);
    int gap;
    for (int i = from; i < to; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
      if ((max_gap > 0) && (i == 1000)) gap = TO - 1;
      drive_byte(i[7:0], gap);
    end
  endtask

  task automatic start_load();
    s_valid_i = 1'b0;
    start_i   = 1'b1;
    start_tok++;
    step();
    start_i = 1'b0;
    chk_flags("start_accepted", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'({wr_en_o, wr_addr_o, wr_data_o, s_ready_o, busy_o, done_o,
                   error_o, req_rom_release_o}), 32'd0);
  endtask

  vec_t tbl[8];
  int   w_base;
  int   r_base;

  initial begin
    system_reset_n = 1'b0;
    start_i        = 1'b0;
    s_valid_i      = 1'b0;
    s_data_i       = 8'h00;

    // start, valid, data, new_load, ready, busy, done, error, release
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    step();
    step();
    chk_all_zero("reset_outputs");
    system_reset_n = 1'b1;

    // Load 1: table-driven opening, then the rest with random gaps.
    w_base = wr_count;
    r_base = rel_rises;
    for (int k = 0; k < 8; k++) begin
      start_i   = tbl[k].start;
      s_valid_i = tbl[k].valid;
      s_data_i  = tbl[k].data;
      if (tbl[k].new_load) start_tok++;
      step();
      chk_flags($sformatf("table_row%0d", k), tbl[k].r, tbl[k].b, tbl[k].d,
                tbl[k].e, tbl[k].rel);
    end
    start_i = 1'b0;
    load_bytes(4, DEPTH, 9);
`ifdef CARD_ROM_LOADER_CHECKSUM_EN
    chk_flags("in_check", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    s_data_i = 8'h00;
    step();
    chk_flags("check_pass_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`else
    chk_flags("done_after_last", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    s_data_i = 8'hAA;
    repeat (3) step();
    chk_flags("no_extra_byte", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    s_valid_i = 1'b0;
    step();
    chk("write_count_load1", 32'(wr_count - w_base), 32'(DEPTH));
    chk("release_rises_load1", 32'(rel_rises - r_base), 32'd1);

`ifdef CARD_ROM_LOADER_CHECKSUM_EN
    // Load 2: same image, bad checksum byte.
    w_base = wr_count;
    r_base = rel_rises;
    start_load();
    load_bytes(0, DEPTH, 0);
    chk_flags("in_check_2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    s_data_i = 8'h01;
    step();
    chk_flags("check_fail_error", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    s_valid_i = 1'b0;
    repeat (2) step();
    chk("write_count_badsum", 32'(wr_count - w_base), 32'(DEPTH));
    chk("release_rises_badsum", 32'(rel_rises - r_base), 32'd0);
`endif

    // Stall after byte 100 until the timeout expires.
    w_base = wr_count;
    start_load();
    load_bytes(0, 101, 0);
    s_valid_i = 1'b0;
    repeat (TO - 1) step();
    chk_flags("timeout_not_yet", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_flags("timeout_expiry", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    s_valid_i = 1'b1;
    s_data_i  = 8'h55;
    repeat (3) step();
    chk_flags("ready_low_after_timeout", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    s_valid_i = 1'b0;
    step();
    chk("write_count_timeout", 32'(wr_count - w_base), 32'd101);

    // Reset pulse while byte 500 is offered.
    w_base = wr_count;
    start_load();
    load_bytes(0, 500, 0);
    s_valid_i      = 1'b1;
    s_data_i       = 8'hF4;
    system_reset_n = 1'b0;
    step();
    chk_all_zero("reset_mid_load");
    system_reset_n = 1'b1;
    step();
    chk_flags("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("write_count_reset", 32'(wr_count - w_base), 32'd500);
    chk("queue_empty_reset", 32'(exp_q.size()), 32'd0);

    // Reload restarts from address 0.
    w_base = wr_count;
    start_load();
    load_bytes(0, 10, 3);
    s_valid_i = 1'b0;
    repeat (2) step();
    chk("write_count_reload", 32'(wr_count - w_base), 32'd10);
    chk("queue_empty_reload", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/card_rom_loader.md
CARD_ROM_LOADER -- requirements
Module: card_rom_loader

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 2048, number of card-ROM bytes written per load.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, maximum number of idle cycles between bytes while loading.
REQ-003 SHALL have port clk_logic  input  1  single clock for all logic.
REQ-004 SHALL have port system_reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start_i  input  1  pulse that begins a load.
REQ-006 SHALL have ports s_data_i  input  8, s_valid_i  input  1, s_ready_o  output  1: the image byte stream.
REQ-007 SHALL have ports wr_addr_o  output  11, wr_data_o  output  8, wr_en_o  output  1: card-ROM RAM write port.
REQ-008 SHALL have ports busy_o, done_o, error_o  output  1 each: status flags.
REQ-009 SHALL have port req_rom_release_o  output  1: level request to the card-ROM responder to release the ROM after a good load.

Function
REQ-010 SHALL implement the states IDLE, LOAD, CHECK, DONE and ERROR.
REQ-011 SHALL move from IDLE, DONE or ERROR to LOAD on start_i, clearing the byte counter, checksum, timeout counter and all status flags.
REQ-012 SHALL ignore start_i in LOAD and CHECK.
REQ-013 SHALL drive s_ready_o high only in LOAD and CHECK; a byte transfers on any cycle where s_valid_i and s_ready_o are both high.
REQ-014 SHALL, for each LOAD transfer, register wr_en_o=1, wr_addr_o=byte index and wr_data_o=s_data_i on the next cycle, giving one cycle of latency.
REQ-015 SHALL hold wr_en_o at 0 in all other cycles and accept back-to-back transfers, one per cycle.
REQ-016 SHALL advance on the transfer of byte index ROM_DEPTH-1 without wrapping the counter: to CHECK when checksum is enabled, otherwise to DONE.
REQ-017 SHALL keep an 8-bit modulo-256 sum of all transferred bytes.
REQ-018 SHALL accept exactly one byte in CHECK without writing it to the RAM.
REQ-019 SHALL go from CHECK to DONE if the sum including the CHECK byte is 0x00, otherwise to ERROR.
REQ-020 SHALL count cycles without a transfer in LOAD and CHECK and go to ERROR when the count reaches TIMEOUT_CYCLES; any transfer resets the count to 0.
REQ-021 SHALL take the transfer when a transfer and timeout expiry occur in the same cycle.
REQ-022 SHALL drive busy_o=1 in LOAD and CHECK, done_o=1 in DONE and error_o=1 in ERROR.
REQ-023 SHALL drive req_rom_release_o=1 only in DONE and hold it until reset or start_i; the consumer detects the rising edge.
REQ-024 SHALL never assert req_rom_release_o from ERROR.

Reset
REQ-025 SHALL, while system_reset_n=0 at a clk_logic edge, enter IDLE with every output 0, including wr_addr_o and wr_data_o.
REQ-026 SHALL abort a load in progress on reset with no further writes, leaving partially written RAM as is.

Configuration
REQ-027 SHALL include the CHECK state and checksum (REQ-017 to REQ-019) when macro CARD_ROM_LOADER_CHECKSUM_EN is defined.
REQ-028 SHALL, without the macro, go from the last LOAD byte directly to DONE with no checksum logic, so ERROR is reachable only by timeout.

Structure
REQ-029 SHALL take the state enum, ROM_ADDR_W=11 and the default depth and timeout constants from shared package cardrom_pkg.
REQ-030 SHALL place the modulo-256 accumulator in sub-module card_rom_checksum (clear, add_en, data, sum_is_zero), instantiated only under CARD_ROM_LOADER_CHECKSUM_EN.

Verification
REQ-031 SHALL verify: reset, start_i pulse, 2048 bytes (byte i = i[7:0]) plus checksum 0x00 (sum of bytes = 0x00) -> 2048 writes, addr 0..2047 in order, done_o=1, req_rom_release_o rises once.
REQ-032 SHALL verify: same image, checksum byte 0x01 -> error_o=1, req_rom_release_o stays 0, exactly 2048 writes.
REQ-033 SHALL verify: random s_valid_i gaps under 10 cycles with TIMEOUT_CYCLES=16 -> no timeout, wr_en_o exactly one cycle after each handshake.
REQ-034 SHALL verify: stream stalls 16 cycles after byte 100 with TIMEOUT_CYCLES=16 -> error_o=1 on the expiry cycle and s_ready_o=0 afterwards.
REQ-035 SHALL verify: system_reset_n low for one cycle at byte 500 -> all outputs 0 on the next cycle; a new start_i then reloads from addr 0.
REQ-036 SHALL verify: without the macro, 2048 bytes -> done_o=1 with no extra byte accepted; start_i in DONE clears req_rom_release_o and restarts the load.
